coresysservices_ahbl_slave_if: RTL

AHB-Lite slave front-end for the CoreSysServices fabric: the responder end of the AHB-Lite bus that the services master interface drives. It samples address phases, converts each accepted transfer into a single request/acknowledge handshake on a backend register/FSM port, inserts wait states until the backend answers, and returns OKAY or the two-cycle ERROR response. It sits between the fabric interconnect and the services register bank.

---
 rtl/coresysservices_ahbl_pkg.sv | 21 ++
 rtl/coresysservices_ahbl_if.sv | 30 +++
 rtl/coresysservices_ahbl_timeout.sv | 18 +
 rtl/coresysservices_ahbl_slave_if.sv | 61 ++++++
 4 files changed

// File: rtl/coresysservices_ahbl_pkg.sv
// coresysservices_ahbl_pkg: shared AHB-Lite encodings, slave FSM states and transfer legality helper
package coresysservices_ahbl_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_MAX = 3'b010;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;
  // Oversized or misaligned transfers are refused without touching the backend
  function automatic logic size_illegal(logic [2:0] size, logic [1:0] addr_lo);
    return size > HSIZE_MAX || (size == 3'b001 && addr_lo[0]) || (size == HSIZE_MAX && addr_lo != 2'b00);
  endfunction
endpackage

// File: rtl/coresysservices_ahbl_if.sv
// coresysservices_ahbl_if: AHB-Lite slave bus plus backend request/ack port
interface coresysservices_ahbl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        req_o;
  logic        wr_o;
  logic [31:0] addr_o;
  logic [2:0]  size_o;
  logic [31:0] wdata_o;
  logic        ack_i;
  logic        err_i;
  logic [31:0] rdata_i;
  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY, ack_i, err_i, rdata_i,
    output HREADYOUT, HRESP, HRDATA, req_o, wr_o, addr_o, size_o, wdata_o
  );
  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY, ack_i, err_i, rdata_i,
    input  HREADYOUT, HRESP, HRDATA, req_o, wr_o, addr_o, size_o, wdata_o
  );
endinterface

// File: rtl/coresysservices_ahbl_timeout.sv
// coresysservices_ahbl_timeout: backend acknowledge watchdog, counts cycles spent in ACCESS
module coresysservices_ahbl_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt;
  // Held at zero outside ACCESS, so every entry starts a fresh count
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= active ? cnt + 1'b1 : '0;
  assign expired = active && cnt == LAST;
endmodule

// File: rtl/coresysservices_ahbl_slave_if.sv
// coresysservices_ahbl_slave_if: AHB-Lite slave front-end turning transfers into backend req/ack handshakes
// Optional ACCESS watchdog enabled by defining CORESYSSERVICES_AHBL_TIMEOUT_EN.
module coresysservices_ahbl_slave_if
  import coresysservices_ahbl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic HCLK,
  input logic HRESET,
  coresysservices_ahbl_if.slave bus
);
  state_t state, state_nx;
  logic accept, illegal, sample, timeout, wr;
  logic [31:0] addr, hrdata;
  logic [2:0] size;
  // DONE and ERR2 take pipelined address phases just like IDLE
  assign sample = state != ST_ACCESS && state != ST_ERR1;
  assign accept = sample && bus.HSEL && bus.HREADY && !(bus.HTRANS inside {HTRANS_IDLE, HTRANS_BUSY});
  assign illegal = size_illegal(bus.HSIZE, bus.HADDR[1:0]);
`ifdef CORESYSSERVICES_AHBL_TIMEOUT_EN
  coresysservices_ahbl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(HCLK),
    .rst(HRESET),
    .active(state == ST_ACCESS),
    .expired(timeout)
  );
`else
  assign timeout = TIMEOUT_CYCLES == 0;
`endif
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state <= ST_IDLE;
    else state <= state_nx;
  // An acknowledge in the expiry cycle wins over the watchdog
  always_comb begin
    state_nx = accept ? (illegal ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
    if (state == ST_ACCESS) state_nx = bus.ack_i ? (bus.err_i ? ST_ERR1 : ST_DONE) : (timeout ? ST_ERR1 : ST_ACCESS);
    else if (state == ST_ERR1) state_nx = ST_ERR2;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      wr     <= 1'b0;
      addr   <= '0;
      size   <= '0;
      hrdata <= '0;
    end else begin
      if (accept) begin
        wr   <= bus.HWRITE;
        addr <= bus.HADDR;
        size <= bus.HSIZE;
      end
      if (state == ST_ACCESS && bus.ack_i && !bus.err_i && !wr) hrdata <= bus.rdata_i;
    end
  assign bus.HREADYOUT = !(state == ST_ACCESS || state == ST_ERR1);
  assign bus.HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = hrdata;
  assign bus.req_o     = state == ST_ACCESS;
  assign bus.wr_o      = wr;
  assign bus.addr_o    = addr;
  assign bus.size_o    = size;
  assign bus.wdata_o   = bus.req_o ? bus.HWDATA : '0;
endmodule
